cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) between the out-of-order core's functional units (ALU, mul/div, load path). Each unit presents a completed result as a `cdb_t` with a valid/ready handshake. The arbiter grants one requester per cycle and drives the granted result onto a registered CDB. The CDB feeds the ROB, the physical regfile write port and the reservation-station wakeup logic.

## Interface
- `NUM_REQ`, default 3: number of requesters; index 0 = ALU, 1 = mul/div, 2 = load. Legal range 2..8.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: branch-mispredict flush; kills in-flight grant and output.
- `req_valid` in `NUM_REQ`: requester i holds a completed result.
- `req_data` in `NUM_REQ` x `cdb_t`: result payload per requester; its `.ready` field is ignored.
- `req_ready` out `NUM_REQ`: grant. Combinational, one-hot or zero.
- `cdb_out` out `cdb_t`: registered CDB broadcast; `.ready`=1 marks a valid broadcast.

## Operation
- State:
  - `rr_ptr` (`$clog2(NUM_REQ)` bits): highest-priority index.
  - `cdb_q` (`cdb_t`): output register.
- Arbitration (combinational):
  - Scan indices `rr_ptr`, `rr_ptr+1`, ... mod `NUM_REQ`.
  - The first i with `req_valid[i]`=1 gets `req_ready[i]`=1. All others are 0.
- Gating: when `flush`=1 or `rst`=1, all `req_ready`=0.
- Transfer: occurs for i when `req_valid[i] && req_ready[i]`.
  - Next cycle, `cdb_q` gets `req_data[i]` with `.ready` forced to 1.
  - Next cycle, `rr_ptr` gets (i+1) mod `NUM_REQ`. Wrap from `NUM_REQ-1` goes to 0.
- No transfer: next cycle, `cdb_q` becomes all-zero. `rr_ptr` is unchanged.
- Requester rule: `req_valid` and `req_data` must stay stable until `req_ready`. The arbiter never drops an accepted result.
- `flush`:
  - Next cycle, `cdb_q` = 0.
  - `rr_ptr` is unchanged.
  - Requesters drop their own valids; the arbiter holds no queued state.
- Starvation bound: a continuously valid requester is granted within `NUM_REQ` cycles.

## Timing
- Reset values: `cdb_out` = all zero (including `.ready`=0); `rr_ptr` = 0; `req_ready` = 0 during `rst`.
- Latency: grant in cycle N gives `cdb_out.ready`=1 for exactly cycle N+1. Maximum one broadcast per cycle.
- Back-to-back grants to different or same requesters each produce consecutive single-cycle broadcasts.
- `req_ready` depends combinationally on `req_valid`, `rr_ptr` and `flush`. It has no dependence on `req_data`.
- Same-cycle `flush` and `req_valid`: no grant, no broadcast in N+1.
- `rst` mid-operation: overrides everything; the pending broadcast is lost.

## Configuration
- `CDB_ARB_PERF_EN` defined:
  - Adds output `stall_cnt` `NUM_REQ` x 32.
  - Per-requester counter increments on each cycle where `req_valid[i] && !req_ready[i]`. The count includes flush cycles.
  - Counters saturate at 32'hFFFF_FFFF.
  - Counters clear on `rst` only; `flush` does not clear them.
- `CDB_ARB_PERF_EN` undefined: the port and counters are absent. Arbitration behaviour is identical.

## Test plan
- Reset then idle:
  - Stimulus: `rst`=1 for 2 cycles, then all valids 0 for 5 cycles.
  - Required response: `cdb_out` stays 0, `req_ready` stays 0.
- Single requester:
  - Stimulus: `req_valid`=3'b010, `rob_id`=5'd7, `pr_dest`=6'd33, `result`=32'hDEADBEEF, held 1 cycle.
  - Required response: `req_ready`=3'b010 that cycle; next cycle `cdb_out` = {ready=1, rob_id=7, pr_dest=33, result=DEADBEEF}; the cycle after, `cdb_out.ready`=0.
- Rotation:
  - Stimulus: all three valid continuously from reset, each requester deasserting after its grant.
  - Required response: grants in order 0, 1, 2; `cdb_out` carries 3 consecutive broadcasts; `rr_ptr` returns to 0.
- Fairness with persistent valids:
  - Stimulus: req0 and req2 both held valid for 6 cycles.
  - Required response: grants alternate 0, 2, 0, 2, 0, 2; req1 is never granted.
- Flush collision:
  - Stimulus: `req_valid`=3'b001 with `flush`=1 in the same cycle.
  - Required response: `req_ready`=0 and no broadcast next cycle; after flush deasserts, the grant goes to 0 from the unchanged pointer.
- Perf counters (with `CDB_ARB_PERF_EN` defined):
  - Stimulus: req0 and req1 valid for 4 cycles, starting at `rr_ptr`=0.
  - Required response: `stall_cnt[1]`=2, `stall_cnt[0]`=2 after 4 cycles; counters hold across `flush`.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus (CDB).
// Requesters (0 = ALU, 1 = mul/div, 2 = load by default) present a
// completed result with a valid/ready handshake. One grant per cycle.
// The granted payload is broadcast from a register one cycle later.
//
// Optional feature: define CDB_ARB_PERF_EN to add the per-requester
// saturating stall counters on output stall_cnt.

package cdb_arbiter_pkg;

  // One CDB broadcast. On the output, ready=1 marks a valid broadcast.
  // On requester inputs the ready field carries no meaning.
  typedef struct packed {
    logic        ready;
    logic [4:0]  rob_id;
    logic [5:0]  pr_dest;
    logic [31:0] result;
  } cdb_t;

endpackage

module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  cdb_t [NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output cdb_t                    cdb_out
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_REQ-1:0][31:0] stall_cnt
`endif
);

  // Width of the round-robin pointer and of a requester index.
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin state and output register.
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  cdb_t          cdb_q,    cdb_d;

  // Arbitration intermediates.
  logic [NUM_REQ-1:0] rot_valid;   // req_valid rotated so bit 0 = rr_ptr
  logic [PW-1:0]      win_off;     // winner's distance from rr_ptr
  logic               any_valid;
  logic [PW:0]        idx_sum;     // rr_ptr + win_off before the modulo
  logic [PW-1:0]      win_idx;     // absolute index of the winner
  logic               grant_vld;   // a transfer happens this cycle

  // Rotate the request vector right by rr_ptr so that a fixed-priority
  // search from bit 0 becomes a round-robin search from rr_ptr.
  always_comb begin
    rot_valid = (req_valid >> rr_ptr_q)
              | (req_valid << (NUM_REQ - int'(rr_ptr_q)));
  end

  // Find the lowest set bit of the rotated vector. The loop runs from the
  // top down so the last hit (lowest index) wins without an early exit.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    win_off   = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_off   = PW'(k);
        any_valid = 1'b1;
      end
    end
  end

  // Map the winner's offset back to an absolute index, modulo NUM_REQ.
  always_comb begin
    idx_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (idx_sum >= (PW + 1)'(NUM_REQ)) begin
      win_idx = PW'(idx_sum - (PW + 1)'(NUM_REQ));
    end else begin
      win_idx = PW'(idx_sum);
    end
  end

  // Grant is gated by flush and reset; it never looks at req_data.
  assign grant_vld = any_valid && !flush && !rst;

  // Drive the one-hot (or zero) grant vector.
  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = grant_vld && (win_idx == PW'(k));
    end
  end

  // Next pointer and next broadcast: on a transfer the pointer moves just
  // past the winner and the payload is latched with ready forced high;
  // otherwise the pointer holds and the bus goes idle (all zero).
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    cdb_d    = '0;
    if (grant_vld) begin
      rr_ptr_d    = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
      cdb_d       = req_data[win_idx];
      cdb_d.ready = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from before the edge, independent of order.
    if (rst) begin
      rr_ptr_q <= '0;
      cdb_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cdb_q    <= cdb_d;
    end
  end

  assign cdb_out = cdb_q;

`ifdef CDB_ARB_PERF_EN
  // Per-requester stall counters: a requester stalls in any cycle it is
  // valid but not granted, including flush cycles. Counters saturate at
  // all-ones and clear on reset only.
  logic [NUM_REQ-1:0][31:0] stall_q;

  // Count stalled cycles per requester, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_valid[i] && !req_ready[i] && (stall_q[i] != 32'hFFFF_FFFF)) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed, table-driven bench for cdb_arbiter (NUM_REQ=3).
// Each table row gives the inputs for one cycle, the required grant in that
// cycle and which requester's payload must be on cdb_out in that cycle
// (-1 = idle bus). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.

module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [N-1:0]     req_valid;
  cdb_t [N-1:0]     req_data;
  logic [N-1:0]     req_ready;
  cdb_t             cdb_out;
`ifdef CDB_ARB_PERF_EN
  logic [N-1:0][31:0] stall_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_out   (cdb_out)
`ifdef CDB_ARB_PERF_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  typedef struct {
    logic         rst;
    logic         flush;
    logic [N-1:0] valid;
    logic [N-1:0] exp_ready;
    int           exp_src;
  } vec_t;

  vec_t vecs[$];
  cdb_t pl[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic [N-1:0] v,
                     input logic [N-1:0] er, input int src);
    vec_t t;
    t.rst = r; t.flush = f; t.valid = v; t.exp_ready = er; t.exp_src = src;
    vecs.push_back(t);
  endtask

  function automatic cdb_t exp_cdb(input int src);
    cdb_t c;
    c = '0;
    if (src >= 0) begin
      c       = pl[src];
      c.ready = 1'b1;
    end
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic granted;

    pl[0] = '{ready: 1'b0, rob_id: 5'd1, pr_dest: 6'd10, result: 32'h1111_0000};
    pl[1] = '{ready: 1'b0, rob_id: 5'd7, pr_dest: 6'd33, result: 32'hDEAD_BEEF};
    pl[2] = '{ready: 1'b1, rob_id: 5'd3, pr_dest: 6'd12, result: 32'h2222_2222};
    for (int i = 0; i < N; i++) req_data[i] = pl[i];

    rst = 1'b1; flush = 1'b0; req_valid = '0;
    next_cycle();

    //   rst   flush valid   ready   cdb src
    // reset then idle
    add(1'b1, 1'b0, 3'b000, 3'b000, -1);
    add(1'b1, 1'b0, 3'b111, 3'b000, -1);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 3'b000, 3'b000, -1);
    // single requester 1 (pointer ends at 2)
    add(1'b0, 1'b0, 3'b010, 3'b010, -1);
    add(1'b0, 1'b0, 3'b000, 3'b000,  1);
    add(1'b0, 1'b0, 3'b000, 3'b000, -1);
    // reset pulls pointer back to 0, then rotation 0,1,2
    add(1'b1, 1'b0, 3'b000, 3'b000, -1);
    add(1'b0, 1'b0, 3'b111, 3'b001, -1);
    add(1'b0, 1'b0, 3'b110, 3'b010,  0);
    add(1'b0, 1'b0, 3'b100, 3'b100,  1);
    add(1'b0, 1'b0, 3'b000, 3'b000,  2);
    add(1'b0, 1'b0, 3'b000, 3'b000, -1);
    // fairness: req0 and req2 held for 6 cycles
    add(1'b0, 1'b0, 3'b101, 3'b001, -1);
    add(1'b0, 1'b0, 3'b101, 3'b100,  0);
    add(1'b0, 1'b0, 3'b101, 3'b001,  2);
    add(1'b0, 1'b0, 3'b101, 3'b100,  0);
    add(1'b0, 1'b0, 3'b101, 3'b001,  2);
    add(1'b0, 1'b0, 3'b101, 3'b100,  0);
    add(1'b0, 1'b0, 3'b000, 3'b000,  2);
    // flush collision, then flush with pointer at 1
    add(1'b0, 1'b1, 3'b001, 3'b000, -1);
    add(1'b0, 1'b0, 3'b001, 3'b001, -1);
    add(1'b0, 1'b1, 3'b011, 3'b000,  0);
    add(1'b0, 1'b0, 3'b011, 3'b010, -1);
    add(1'b0, 1'b0, 3'b000, 3'b000,  1);
    // reset mid-operation loses the grant attempted in the reset cycle
    add(1'b0, 1'b0, 3'b100, 3'b100, -1);
    add(1'b1, 1'b0, 3'b011, 3'b000,  2);
    add(1'b0, 1'b0, 3'b011, 3'b001, -1);
    add(1'b0, 1'b0, 3'b010, 3'b010,  0);
    add(1'b0, 1'b0, 3'b000, 3'b000,  1);

    foreach (vecs[i]) begin
      rst       = vecs[i].rst;
      flush     = vecs[i].flush;
      req_valid = vecs[i].valid;
      @(negedge clk);
      check($sformatf("v%0d req_ready", i), {61'b0, req_ready}, {61'b0, vecs[i].exp_ready});
      check($sformatf("v%0d cdb_out", i), {20'b0, cdb_out}, {20'b0, exp_cdb(vecs[i].exp_src)});
      next_cycle();
    end

    // Starvation bound: pointer is at 2, all valid; req0 must win on cycle 2.
    req_valid = 3'b111;
    granted   = 1'b0;
    waited    = 0;
    for (int c = 1; c <= N; c++) begin
      @(negedge clk);
      if (!granted && req_ready[0]) begin
        granted = 1'b1;
        waited  = c;
      end
      next_cycle();
    end
    check("starve req0 grant cycle", 64'(waited), 64'd2);
    req_valid = 3'b000;
    @(negedge clk);
    check("starve last broadcast", {20'b0, cdb_out}, {20'b0, exp_cdb(1)});
    next_cycle();

`ifdef CDB_ARB_PERF_EN
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 3'b011;
      @(negedge clk);
      check($sformatf("perf c%0d req_ready", c), {61'b0, req_ready},
            (c % 2 == 0) ? 64'd1 : 64'd2);
      next_cycle();
    end
    req_valid = 3'b000;
    @(negedge clk);
    check("perf stall0", {32'b0, stall_cnt[0]}, 64'd2);
    check("perf stall1", {32'b0, stall_cnt[1]}, 64'd2);
    check("perf stall2", {32'b0, stall_cnt[2]}, 64'd0);
    next_cycle();
    flush = 1'b1;
    next_cycle();
    next_cycle();
    req_valid = 3'b100;
    next_cycle();
    flush = 1'b0;
    req_valid = 3'b000;
    @(negedge clk);
    check("perf hold stall0", {32'b0, stall_cnt[0]}, 64'd2);
    check("perf hold stall1", {32'b0, stall_cnt[1]}, 64'd2);
    check("perf flush stall2", {32'b0, stall_cnt[2]}, 64'd1);
    next_cycle();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
